// File: rtl/gray_sync_decoder.sv
// gray_sync_decoder: brings a Gray-coded word (pointer/counter from another
// clock domain) into clk through a flop synchronizer, decodes it to binary,
// reports the modulo movement between consecutive samples and flags samples
// that differ from their predecessor in more than one bit.
module gray_sync_decoder #(
  parameter int WIDTH       = 6,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] gray_in,
  input  logic             clr_err,
  output logic [WIDTH-1:0] binary_out,
  output logic             bin_valid,
  output logic [WIDTH-1:0] delta,
  output logic             change,
  output logic             err_multi,
  output logic [7:0]       err_count
);

  // Warm-up counter only has to reach SYNC_STAGES, then it parks there.
  localparam int             CNT_W     = $clog2(SYNC_STAGES + 1);
  localparam logic [CNT_W-1:0] WARM_LAST = CNT_W'(SYNC_STAGES);

  // Gray -> binary: MSB passes through, each lower bit XORs the bit above.
  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // True when the two words differ in more than one bit position.
  function automatic logic multi_bit_diff(input logic [WIDTH-1:0] a,
                                          input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] d;
    int               n;
    d = a ^ b;
    n = 0;
    for (int i = 0; i < WIDTH; i++) begin
      n += int'(d[i]);
    end
    return (n > 1);
  endfunction

  // Saturating +1 for the 8-bit violation counter.
  function automatic logic [7:0] sat_inc8(input logic [7:0] c);
    return (c == 8'hFF) ? c : c + 8'd1;
  endfunction

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_d [SYNC_STAGES];
  logic [WIDTH-1:0] gray_prev_q, gray_prev_d;
  logic [WIDTH-1:0] binary_out_q, binary_out_d;
  logic [WIDTH-1:0] delta_q, delta_d;
  logic             change_q, change_d;
  logic             bin_valid_q, bin_valid_d;
  logic [CNT_W-1:0] warm_cnt_q, warm_cnt_d;
  logic             err_multi_q, err_multi_d;
  logic [7:0]       err_count_q, err_count_d;

  logic [WIDTH-1:0] samp;
  logic [WIDTH-1:0] new_bin;
  logic             viol;

  // Next-state logic: shift synchronizer, decode newest sample, compare with previous.
  always_comb begin
    sync_d[0] = gray_in;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end

    samp    = sync_q[SYNC_STAGES-1];
    new_bin = gray2bin(samp);

    warm_cnt_d  = warm_cnt_q;
    if (warm_cnt_q != WARM_LAST) begin
      warm_cnt_d = warm_cnt_q + CNT_W'(1);
    end
    // The first post-reset sample lands in binary_out on the edge where the
    // counter has already reached SYNC_STAGES.
    bin_valid_d = bin_valid_q | (warm_cnt_q == WARM_LAST);

    binary_out_d = new_bin;
    gray_prev_d  = samp;

    // Movement and violation checks need a real previous sample to compare to.
    delta_d  = '0;
    change_d = 1'b0;
    viol     = 1'b0;
    if (bin_valid_q) begin
      delta_d  = new_bin - binary_out_q;
      change_d = (delta_d != '0);
      viol     = multi_bit_diff(samp, gray_prev_q);
    end

    // A violation in the same cycle as a clear wins: the clear is absorbed
    // and the counter restarts at one.
    err_multi_d = err_multi_q;
    err_count_d = err_count_q;
    if (viol) begin
      err_multi_d = 1'b1;
      err_count_d = clr_err ? 8'd1 : sat_inc8(err_count_q);
    end else if (clr_err) begin
      err_multi_d = 1'b0;
      err_count_d = 8'd0;
    end
  end

  // State registers; reset clears everything so warm-up restarts cleanly.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
      gray_prev_q  <= '0;
      binary_out_q <= '0;
      delta_q      <= '0;
      change_q     <= 1'b0;
      bin_valid_q  <= 1'b0;
      warm_cnt_q   <= '0;
      err_multi_q  <= 1'b0;
      err_count_q  <= 8'd0;
    end else begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_d[i];
      end
      gray_prev_q  <= gray_prev_d;
      binary_out_q <= binary_out_d;
      delta_q      <= delta_d;
      change_q     <= change_d;
      bin_valid_q  <= bin_valid_d;
      warm_cnt_q   <= warm_cnt_d;
      err_multi_q  <= err_multi_d;
      err_count_q  <= err_count_d;
    end
  end

  assign binary_out = binary_out_q;
  assign bin_valid  = bin_valid_q;
  assign delta      = delta_q;
  assign change     = change_q;
  assign err_multi  = err_multi_q;
  assign err_count  = err_count_q;

endmodule

// File: tb/tb_gray_sync_decoder.sv
// Directed bench for gray_sync_decoder (WIDTH=6, SYNC_STAGES=2).
module tb_gray_sync_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] gray_in;
  logic       clr_err;
  logic [5:0] binary_out;
  logic       bin_valid;
  logic [5:0] delta;
  logic       change;
  logic       err_multi;
  logic [7:0] err_count;

  int total = 0;
  int bad   = 0;

  gray_sync_decoder #(.WIDTH(6), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .gray_in   (gray_in),
    .clr_err   (clr_err),
    .binary_out(binary_out),
    .bin_valid (bin_valid),
    .delta     (delta),
    .change    (change),
    .err_multi (err_multi),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  // Advance one edge, then settle so outputs are read away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reset for one edge with g on the input, then three edges of warm-up.
  task automatic warm_up(input logic [5:0] g);
    rst = 1'b1; gray_in = g; clr_err = 1'b0;
    step();
    rst = 1'b0;
    step(); step(); step();
  endtask

  task automatic test_reset();
    rst = 1'b1; gray_in = 6'b000001; clr_err = 1'b0;
    step(); step();
    total++;
    if ({binary_out, bin_valid, delta, change, err_multi, err_count} !== 23'd0) begin
      bad++; $display("FAIL reset_outputs: got bin=%0d vld=%0b dlt=%0d chg=%0b em=%0b ec=%0d want all 0",
                      binary_out, bin_valid, delta, change, err_multi, err_count);
    end
    rst = 1'b0;
    for (int k = 1; k <= 2; k++) begin
      step();
      total++;
      if ({binary_out, bin_valid, change, err_multi} !== 9'd0) begin
        bad++; $display("FAIL warmup_edge%0d: got bin=%0d vld=%0b chg=%0b em=%0b want 0 0 0 0",
                        k, binary_out, bin_valid, change, err_multi);
      end
    end
    step();
    total++;
    if (binary_out !== 6'd1 || bin_valid !== 1'b1) begin
      bad++; $display("FAIL warmup_first: got bin=%0d vld=%0b want bin=1 vld=1", binary_out, bin_valid);
    end
    total++;
    if (change !== 1'b0 || delta !== 6'd0 || err_multi !== 1'b0) begin
      bad++; $display("FAIL warmup_quiet: got chg=%0b dlt=%0d em=%0b want 0 0 0", change, delta, err_multi);
    end
  endtask

  task automatic test_counting();
    logic [5:0] vec [5];
    logic [5:0] ebin [5];
    logic [5:0] edlt [5];
    vec  = '{6'b000000, 6'b000001, 6'b000011, 6'b000010, 6'b000110};
    ebin = '{6'd0, 6'd1, 6'd2, 6'd3, 6'd4};
    edlt = '{6'd63, 6'd1, 6'd1, 6'd1, 6'd1};  // first step is 1 -> 0
    for (int j = 1; j <= 7; j++) begin
      if (j <= 5) gray_in = vec[j-1];
      step();
      if (j >= 3) begin
        total++;
        if (binary_out !== ebin[j-3] || delta !== edlt[j-3] || change !== 1'b1 || err_multi !== 1'b0) begin
          bad++; $display("FAIL count_%0d: got bin=%0d dlt=%0d chg=%0b em=%0b want bin=%0d dlt=%0d chg=1 em=0",
                          j - 3, binary_out, delta, change, err_multi, ebin[j-3], edlt[j-3]);
        end
      end
    end
  endtask

  task automatic test_steady();
    step(); step();
    total++;
    if (binary_out !== 6'd4 || delta !== 6'd0 || change !== 1'b0 || err_count !== 8'd0) begin
      bad++; $display("FAIL steady: got bin=%0d dlt=%0d chg=%0b ec=%0d want bin=4 dlt=0 chg=0 ec=0",
                      binary_out, delta, change, err_count);
    end
  endtask

  task automatic test_wrap();
    warm_up(6'b100001);  // binary 62
    total++;
    if (binary_out !== 6'd62 || bin_valid !== 1'b1) begin
      bad++; $display("FAIL wrap_start: got bin=%0d vld=%0b want bin=62 vld=1", binary_out, bin_valid);
    end
    gray_in = 6'b100000;
    step(); step(); step();
    total++;
    if (binary_out !== 6'd63 || delta !== 6'd1 || change !== 1'b1 || err_multi !== 1'b0) begin
      bad++; $display("FAIL wrap_63: got bin=%0d dlt=%0d chg=%0b em=%0b want 63 1 1 0",
                      binary_out, delta, change, err_multi);
    end
    gray_in = 6'b000000;
    step(); step(); step();
    total++;
    if (binary_out !== 6'd0 || delta !== 6'd1 || change !== 1'b1 || err_multi !== 1'b0) begin
      bad++; $display("FAIL wrap_0: got bin=%0d dlt=%0d chg=%0b em=%0b want 0 1 1 0",
                      binary_out, delta, change, err_multi);
    end
  endtask

  task automatic test_violation();
    gray_in = 6'b000011;
    step(); step(); step();
    total++;
    if (binary_out !== 6'd2 || delta !== 6'd2 || change !== 1'b1 || err_multi !== 1'b1 || err_count !== 8'd1) begin
      bad++; $display("FAIL viol_first: got bin=%0d dlt=%0d chg=%0b em=%0b ec=%0d want 2 2 1 1 1",
                      binary_out, delta, change, err_multi, err_count);
    end
    for (int k = 1; k <= 4; k++) begin
      gray_in = (k % 2 == 1) ? 6'b000000 : 6'b000011;
      step(); step(); step();
      total++;
      if (err_count !== 8'(k + 1) || err_multi !== 1'b1) begin
        bad++; $display("FAIL viol_repeat%0d: got ec=%0d em=%0b want ec=%0d em=1", k, err_count, err_multi, k + 1);
      end
    end
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    total++;
    if (err_multi !== 1'b0 || err_count !== 8'd0) begin
      bad++; $display("FAIL viol_clear: got em=%0b ec=%0d want 0 0", err_multi, err_count);
    end
  endtask

  task automatic test_clear_collision();
    gray_in = 6'b000000;
    step(); step(); step();
    total++;
    if (err_count !== 8'd1) begin
      bad++; $display("FAIL coll_pre: got ec=%0d want 1", err_count);
    end
    gray_in = 6'b000011;
    step(); step();
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    total++;
    if (err_multi !== 1'b1 || err_count !== 8'd1 || binary_out !== 6'd2) begin
      bad++; $display("FAIL coll_win: got em=%0b ec=%0d bin=%0d want em=1 ec=1 bin=2",
                      err_multi, err_count, binary_out);
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 300; i++) begin
      gray_in = (i % 2 == 0) ? 6'b000000 : 6'b000011;
      step();
      if (i == 9) begin
        total++;
        if (err_count !== 8'd9) begin
          bad++; $display("FAIL sat_mid: got ec=%0d want 9", err_count);
        end
      end
    end
    step(); step();
    total++;
    if (err_count !== 8'd255 || err_multi !== 1'b1) begin
      bad++; $display("FAIL sat_top: got ec=%0d em=%0b want 255 1", err_count, err_multi);
    end
    step(); step(); step();
    total++;
    if (err_count !== 8'd255 || change !== 1'b0) begin
      bad++; $display("FAIL sat_hold: got ec=%0d chg=%0b want 255 0", err_count, change);
    end
  endtask

  task automatic test_midstream_reset();
    warm_up(6'b000000);
    gray_in = 6'b000001; step();
    gray_in = 6'b000011; step();
    gray_in = 6'b000010; step();
    rst = 1'b1; gray_in = 6'b100000;
    step();
    total++;
    if ({binary_out, bin_valid, delta, change, err_multi, err_count} !== 23'd0) begin
      bad++; $display("FAIL mid_reset: got bin=%0d vld=%0b dlt=%0d chg=%0b em=%0b ec=%0d want all 0",
                      binary_out, bin_valid, delta, change, err_multi, err_count);
    end
    rst = 1'b0;
    for (int k = 1; k <= 2; k++) begin
      step();
      total++;
      if ({binary_out, bin_valid, change, err_multi} !== 9'd0) begin
        bad++; $display("FAIL mid_warm%0d: got bin=%0d vld=%0b chg=%0b em=%0b want 0 0 0 0",
                        k, binary_out, bin_valid, change, err_multi);
      end
    end
    step();
    total++;
    if (binary_out !== 6'd63 || bin_valid !== 1'b1 || change !== 1'b0 || delta !== 6'd0 ||
        err_multi !== 1'b0 || err_count !== 8'd0) begin
      bad++; $display("FAIL mid_resume: got bin=%0d vld=%0b chg=%0b dlt=%0d em=%0b ec=%0d want 63 1 0 0 0 0",
                      binary_out, bin_valid, change, delta, err_multi, err_count);
    end
  endtask

  initial begin
    rst = 1'b1; gray_in = '0; clr_err = 1'b0;
    test_reset();
    test_counting();
    test_steady();
    test_wrap();
    test_violation();
    test_clear_collision();
    test_saturation();
    test_midstream_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gray_sync_decoder.md
Name: gray_sync_decoder

Overview:
- Downstream consumer of Gray-coded words such as pointers or counters, typically produced in another clock domain by the binary-to-Gray stage.
- Synchronizes the Gray word into the local clock and decodes it back to binary.
- Reports per-sample movement (modulo delta).
- Flags any Gray-code violation, i.e. more than one bit changing between consecutive samples, with a sticky flag and a saturating counter.

Parameters:
- WIDTH, 6, bit width of Gray input and binary output (>=2).
- SYNC_STAGES, 2, synchronizer flop depth (>=2).

Ports:
- clk  input  1  sole clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- gray_in  input  WIDTH  Gray-coded word; may be asynchronous to clk.
- clr_err  input  1  clears err_multi and err_count (synchronous, single-cycle).
- binary_out  output  WIDTH  decoded binary of latest synchronized sample.
- bin_valid  output  1  binary_out holds a real sample (pipeline warmed up).
- delta  output  WIDTH  (new binary - previous binary) mod 2^WIDTH.
- change  output  1  one-cycle pulse, delta != 0 on this update.
- err_multi  output  1  sticky: a sample differed from its predecessor in >1 bit.
- err_count  output  8  saturating count of violations.

Behaviour:
- Reset (rst=1 at an edge): all sync flops, previous-sample register, binary_out, delta, change, bin_valid, err_multi and err_count go to 0. This applies mid-operation too; warm-up restarts.
- Synchronizer: SYNC_STAGES-deep flop chain on gray_in, no logic between stages.
- Decode stage: at each edge, the last sync flop is converted to binary and registered into binary_out:
  - b[WIDTH-1] = g[WIDTH-1]
  - b[i] = b[i+1] ^ g[i]
  - Purely combinational XOR chain.
- Latency: the gray_in value sampled at edge k appears on binary_out after edge k+SYNC_STAGES. Default latency is 3 edges from sample to output.
- Warm-up:
  - An internal counter starts at 0 on reset and counts edges with rst=0.
  - bin_valid goes 1 at the edge where the first post-reset sample reaches binary_out, i.e. the (SYNC_STAGES+1)th edge after rst release.
  - bin_valid then stays 1 until the next reset.
- Change/delta: evaluated only on updates where bin_valid was already 1 before the edge.
  - delta = new binary - previous binary, WIDTH-bit wrap-around (e.g. 63 -> 0 gives delta=1; 0 -> 63 gives delta=63).
  - change = 1 for exactly that cycle if delta != 0.
  - While warming up, delta=0 and change=0.
- Violation check: Hamming distance between the new and previous synchronized Gray samples, evaluated under the same bin_valid gating as delta.
  - Distance 0 or 1: legal.
  - Distance >1: violation. The sample is still decoded and delta still reported.
- err_multi is set by a violation and cleared only by clr_err or rst.
- err_count increments by 1 per violating update and saturates at 255.
- clr_err in the same cycle as a violation: violation wins. err_multi stays 1 and err_count becomes 1.
- clr_err with no violation: err_multi=0 and err_count=0 next edge.
- Steady input: binary_out holds, delta=0, change=0, no error activity.

Test Plan:
- Reset/warm-up (WIDTH=6, SYNC_STAGES=2): rst for 2 cycles, then gray_in=000001 held -> all outputs 0 on the first two edges after release; third edge gives binary_out=1, bin_valid=1, change=0, err_multi=0.
- Counting: after warm-up drive gray 000000, 000001, 000011, 000010, 000110 one per cycle -> binary_out 0,1,2,3,4 three edges later, delta=1 with change=1 on each step, no error.
- Wrap: gray 100000 (binary 63) then 000000 -> binary_out 63 then 0, delta=1, change=1, err_multi=0.
- Violation: gray 000000 -> 000011 (binary 0 -> 2) -> binary_out=2, delta=2, change=1, err_multi=1, err_count=1. Repeat four times -> err_count=5. Pulse clr_err alone -> err_multi=0, err_count=0.
- Clear collision plus saturation: clr_err asserted in the same cycle the violation reaches the check -> err_multi=1, err_count=1. Then 300 consecutive violations -> err_count=255 and holds.
- Mid-stream reset: while counting, rst=1 for one cycle -> next edge all outputs 0. bin_valid=0 for the first two edges after release, no change pulse or error caused by pre-reset history, and outputs resume on the third edge.
